// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants for the instruction encoder and the control unit.
// Contents: 7-bit major opcodes, encoder format codes, encoder error codes.
package rv_isa_pkg;

   localparam int unsigned OPC_W  = 7;
   localparam int unsigned FMT_W  = 3;
   localparam int unsigned ERRC_W = 2;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;

   // Major opcodes
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

   // Field-bundle format selector
   typedef enum logic [FMT_W-1:0] {
      FMT_OP_IMM  = 3'd0,
      FMT_LOAD    = 3'd1,
      FMT_OP      = 3'd2,
      FMT_JAL     = 3'd3,
      FMT_STORE   = 3'd4,
      FMT_LUI     = 3'd5,
      FMT_BRANCH  = 3'd6,
      FMT_ILLEGAL = 3'd7
   } fmt_e;

   // Error codes, highest priority first: FMT > ADDR > ALIGN > RANGE
   typedef enum logic [ERRC_W-1:0] {
      ERR_FMT   = 2'b00,
      ERR_RANGE = 2'b01,
      ERR_ALIGN = 2'b10,
      ERR_ADDR  = 2'b11
   } err_e;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I instruction packer.
// Ports: fmt/funct3/funct7/rd/rs1/rs2/imm field inputs; word = encoded
// instruction, err_valid/err_code = field error (format, alignment, range).
module rv_instr_pack
   import rv_isa_pkg::*;
#(
   parameter int unsigned CHECK_RANGE = 1
) (
   input  logic [FMT_W-1:0]  fmt,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [REG_W-1:0]  rd,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [XLEN-1:0]   imm,
   output logic [XLEN-1:0]   word,
   output logic              err_valid,
   output logic [ERRC_W-1:0] err_code
);

   localparam bit CHK = (CHECK_RANGE != 0);

   localparam logic signed [XLEN-1:0] I_MIN   = -32'sd2048;
   localparam logic signed [XLEN-1:0] I_MAX   =  32'sd2047;
   localparam logic signed [XLEN-1:0] B_MIN   = -32'sd4096;
   localparam logic signed [XLEN-1:0] B_MAX   =  32'sd4094;
   localparam logic signed [XLEN-1:0] J_MIN   = -32'sd1048576;
   localparam logic signed [XLEN-1:0] J_MAX   =  32'sd1048574;
   localparam logic signed [XLEN-1:0] SH_MAX  =  32'sd31;

   logic signed [XLEN-1:0] simm;
   logic                   bad_fmt;
   logic                   misal;
   logic                   out_rng;
   logic                   i_oob;

   assign simm  = $signed(imm);
   assign i_oob = (simm < I_MIN) || (simm > I_MAX);

   // Field placement and raw error flags per format
   always_comb begin
      word    = '0;
      bad_fmt = 1'b0;
      misal   = 1'b0;
      out_rng = 1'b0;
      case (fmt)
         FMT_OP_IMM: begin
            // Shifts carry funct7 above a 5-bit shamt
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               word    = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
               out_rng = (simm < 0) || (simm > SH_MAX);
            end else begin
               word    = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
               out_rng = i_oob;
            end
         end
         FMT_LOAD: begin
            word    = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            out_rng = i_oob;
         end
         FMT_OP: begin
            word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
         end
         FMT_STORE: begin
            word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            out_rng = i_oob;
         end
         FMT_BRANCH: begin
            word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            misal   = imm[0];
            out_rng = (simm < B_MIN) || (simm > B_MAX);
         end
         FMT_JAL: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            misal   = imm[0];
            out_rng = (simm < J_MIN) || (simm > J_MAX);
         end
         FMT_LUI: begin
            word    = {imm[31:12], rd, OPC_LUI};
            out_rng = (imm[11:0] != 12'd0);
         end
         default: begin
            bad_fmt = 1'b1;
         end
      endcase
   end

   // Format errors always reported; immediate checks only when enabled
   always_comb begin
      err_valid = 1'b0;
      err_code  = ERR_FMT;
      if (bad_fmt) begin
         err_valid = 1'b1;
         err_code  = ERR_FMT;
      end else if (CHK && misal) begin
         err_valid = 1'b1;
         err_code  = ERR_ALIGN;
      end else if (CHK && out_rng) begin
         err_valid = 1'b1;
         err_code  = ERR_RANGE;
      end
   end

endmodule

// File: rtl/imem_prog_encoder.sv
// Instruction encoder and instruction-memory writer.
// Accepts decoded field bundles on a valid/ready stream, packs them into
// RV32I words and writes them to consecutive word addresses from base_addr.
// Ports: clk/rst (sync, active high); start/base_addr open a session;
// in_* field stream; mem_we/mem_addr/mem_wdata write port; busy, done,
// err/err_code (sticky until start), count = words written this session.
module imem_prog_encoder
   import rv_isa_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned CHECK_RANGE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [2:0]         in_fmt,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [31:0]        in_imm,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [31:0]        mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [ADDR_W:0]    count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   // Count value meaning every address of the memory has been written
   localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]  count_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [31:0]       mem_wdata_d;
   logic              done_d;
   logic              err_d;
   logic [1:0]        err_code_d;
   logic              busy_d;
   logic              in_ready_d;

   logic [31:0]       pk_word;
   logic              pk_err;
   logic [1:0]        pk_code;
   logic              ovf;
   logic              acc_err;
   logic [1:0]        acc_code;

   rv_instr_pack #(
      .CHECK_RANGE (CHECK_RANGE)
   ) u_pack (
      .fmt       (in_fmt),
      .funct3    (in_funct3),
      .funct7    (in_funct7),
      .rd        (in_rd),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .imm       (in_imm),
      .word      (pk_word),
      .err_valid (pk_err),
      .err_code  (pk_code)
   );

   // Merge address overflow into the packer's error priority (FMT > ADDR > rest)
   assign ovf = (count == CNT_FULL);

   always_comb begin
      acc_err  = pk_err | ovf;
      acc_code = pk_code;
      if (pk_err && pk_code == ERR_FMT) begin
         acc_code = ERR_FMT;
      end else if (ovf) begin
         acc_code = ERR_ADDR;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      count_d     = count;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      done_d      = 1'b0;
      err_d       = err;
      err_code_d  = err_code;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               wr_addr_d = base_addr;
               count_d   = '0;
               err_d     = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (in_valid && in_ready) begin
               if (acc_err) begin
                  err_d      = 1'b1;
                  err_code_d = acc_code;
                  state_d    = S_ERR;
               end else begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_addr_q;
                  mem_wdata_d = pk_word;
                  wr_addr_d   = wr_addr_q + ADDR_W'(1);
                  count_d     = count + CNT_W'(1);
                  if (in_last) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d     = (state_d != S_IDLE);
      in_ready_d = (state_d == S_RUN);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wr_addr_q <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         count     <= count_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         done      <= done_d;
         err       <= err_d;
         err_code  <= err_code_d;
         busy      <= busy_d;
         in_ready  <= in_ready_d;
      end
   end

endmodule

// File: doc/imem_prog_encoder.md
Name: imem_prog_encoder

Overview:
- Instruction encoder and instruction-memory writer; the producing end of the opcode/funct3/funct7 decode done by the control unit.
- Accepts decoded instruction fields over a valid/ready stream and assembles 32-bit RV32I words in the formats the control unit decodes: OP-IMM, LOAD, OP, JAL, STORE, LUI, BRANCH.
- Writes each word to consecutive instruction-memory word addresses. Used for program loading at bring-up and as a self-check stimulus source.

Parameters:
- ADDR_W, 8, instruction-memory word-address width
- CHECK_RANGE, 1, 1 = immediate range/alignment checking enabled; 0 = immediates truncated silently

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session (sampled in IDLE only)
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  bundle is the last of the session
- in_fmt  in  3  0 OP-IMM, 1 LOAD, 2 OP, 3 JAL, 4 STORE, 5 LUI, 6 BRANCH, 7 illegal
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (OP, and OP-IMM shifts)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte-offset/immediate (LUI: full value, bits 11:0 must be 0)
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, session completed
- err  out  1  sticky; cleared by start or rst
- err_code  out  2  00 bad fmt, 01 imm range, 10 misaligned, 11 address overflow
- count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE. mem_we, done, err, busy, in_ready = 0; mem_addr, mem_wdata, err_code, count = 0. Any pending write is discarded.
- FSM states: IDLE, RUN, DONE, ERR.
- IDLE: in_ready = 0. On start: wr_addr <= base_addr, count <= 0, err <= 0, go to RUN.
- RUN:
  - in_ready = 1. Accept on in_valid & in_ready.
  - Encoding happens in the accept cycle; mem_we, mem_addr and mem_wdata are registered and appear the next cycle (latency 1, throughput 1/cycle).
  - Each write increments wr_addr (mod 2^ADDR_W) and count.
  - Accept with in_last: go to DONE.
- DONE: lasts one cycle. done = 1, coincident with the final mem_we. Then IDLE.
- Encoding, by format:
  - OP-IMM: opcode 0010011. For funct3 001/101, [31:25] = funct7, [24:20] = imm[4:0], and imm must be 0..31. Otherwise [31:20] = imm[11:0].
  - LOAD: 0000011, I-format.
  - OP: 0110011, R-format with funct7.
  - STORE: 0100011; [31:25] = imm[11:5], [11:7] = imm[4:0].
  - BRANCH: 1100011; [31] imm[12], [30:25] imm[10:5], [11:8] imm[4:1], [7] imm[11].
  - JAL: 1101111; [31] imm[20], [30:21] imm[10:1], [20] imm[11], [19:12] imm[19:12]. funct3 ignored.
  - LUI: 0110111; [31:12] = imm[31:12]. funct3 ignored.
- Checks (CHECK_RANGE = 1):
  - I/S formats: imm in [-2048, 2047].
  - BRANCH: imm in [-4096, 4094]. JAL: imm in [-2^20, 2^20 - 2].
  - BRANCH/JAL with imm[0] = 1: code 10.
  - LUI with imm[11:0] != 0: code 01.
  - fmt 7: code 00.
  - Accept when count == 2^ADDR_W: code 11.
  - Priority when several apply: 00 > 11 > 10 > 01.
- On error: no mem_we for that bundle, err = 1, err_code latched, go to ERR. In ERR, in_ready = 0 and busy = 1 until start, which behaves as in IDLE.
- Start pulses while in RUN or DONE are ignored. in_valid is ignored outside RUN.
- An in_last bundle that errors goes to ERR, not DONE.
- rst mid-session: next cycle is IDLE with all outputs at reset values.

Decomposition:
- Shared package rv_isa_pkg:
  - 7-bit opcode constants (OP_IMM, LOAD, OP, JAL, STORE, LUI, BRANCH).
  - fmt codes.
  - err_code constants.
- Sub-module rv_instr_pack: purely combinational. Inputs are the fields; outputs are word, err_valid and err_code. This lets the packer be reused and unit-tested against the control unit.
- The FSM, address counter and output register stay in imem_prog_encoder.

Test Plan:
- start, base_addr = 0x10; OP-IMM f3 = 000, rd = 1, rs1 = 0, imm = 5, last = 0 -> next cycle mem_we = 1, addr 0x10, data 0x00500093.
- Back-to-back, no gaps:
  - OP rd = 3, rs1 = 1, rs2 = 2, f7 = 0 -> 0x002081B3 @0x11.
  - STORE f3 = 010, rs1 = 1, rs2 = 2, imm = 8 -> 0x0020A423 @0x12.
  - BRANCH f3 = 001, rs1 = 1, rs2 = 2, imm = -4, last = 1 -> 0xFE209EE3 @0x13, done with it, count = 4.
- New session base 0: JAL rd = 1, imm = 2048 -> 0x001000EF; LUI rd = 5, imm = 0x12345000, last -> 0x123452B7, done.
- Errors:
  - OP-IMM imm = 2048 -> no mem_we, err = 1, code 01, in_ready = 0 until start.
  - JAL imm = 3 -> code 10.
  - fmt = 7 -> code 00.
- ADDR_W = 2, base 0, five bundles -> four writes at 0..3; fifth gives err code 11, count = 4.
- rst asserted the cycle after an accept -> no mem_we follows, state IDLE, in_ready = 0, count = 0.
